// File: rtl/alu_pkg.sv
// ALU control encoding shared by the issue stage and the ALU.
// Provided here so the slice elaborates on its own.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } risk_alu_e;

    typedef enum logic [1:0] {
        OP_REG,
        OP_IMM,
        OP_PC,
        OP_ZERO
    } risk_alu_operand_selector_e;

    typedef struct packed {
        risk_alu_e                  operation;
        risk_alu_operand_selector_e op1_sel;
        risk_alu_operand_selector_e op2_sel;
        logic                       use_unsigned;
    } alu_control_t;

endpackage

// File: rtl/pipe_pkg.sv
// Pipeline-wide widths, the bundle carried from decode into EX, and
// the operand selection helper used by the issue stage.
package pipe_pkg;
    import alu_pkg::*;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        alu_control_t          ctrl;
        logic [REG_IDX_W-1:0]  rs1_idx;
        logic [REG_IDX_W-1:0]  rs2_idx;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [REG_IDX_W-1:0]  rd;
        logic                  rd_we;
    } ex_bundle_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_state_e;

    function automatic logic [XLEN-1:0] select_operand(
        input risk_alu_operand_selector_e sel,
        input logic [XLEN-1:0]            reg_val,
        input logic [XLEN-1:0]            imm,
        input logic [XLEN-1:0]            pc
    );
        logic [XLEN-1:0] result;
        case (sel)
            OP_REG:  result = reg_val;
            OP_IMM:  result = imm;
            OP_PC:   result = pc;
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode handshake, forwarding buses and ALU-side outputs of the issue stage.
// The slave modport is the stage itself; master is its environment.
interface ex_issue_stage_if;
    import alu_pkg::*;
    import pipe_pkg::*;

    logic                  flush_i;

    logic                  in_valid_i;
    logic                  in_ready_o;
    alu_control_t          in_ctrl_i;
    logic [REG_IDX_W-1:0]  in_rs1_idx_i;
    logic [REG_IDX_W-1:0]  in_rs2_idx_i;
    logic [XLEN-1:0]       in_rs1_val_i;
    logic [XLEN-1:0]       in_rs2_val_i;
    logic [XLEN-1:0]       in_imm_i;
    logic [XLEN-1:0]       in_pc_i;
    logic [REG_IDX_W-1:0]  in_rd_i;
    logic                  in_rd_we_i;

    logic                  fwd_mem_valid_i;
    logic [REG_IDX_W-1:0]  fwd_mem_rd_i;
    logic [XLEN-1:0]       fwd_mem_data_i;
    logic                  fwd_wb_valid_i;
    logic [REG_IDX_W-1:0]  fwd_wb_rd_i;
    logic [XLEN-1:0]       fwd_wb_data_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    alu_control_t          out_ctrl_o;
    logic [XLEN-1:0]       out_op1_o;
    logic [XLEN-1:0]       out_op2_o;
    logic [REG_IDX_W-1:0]  out_rd_o;
    logic                  out_rd_we_o;

    modport slave (
        input  flush_i,
        input  in_valid_i, in_ctrl_i, in_rs1_idx_i, in_rs2_idx_i,
               in_rs1_val_i, in_rs2_val_i, in_imm_i, in_pc_i, in_rd_i, in_rd_we_i,
        output in_ready_o,
        input  fwd_mem_valid_i, fwd_mem_rd_i, fwd_mem_data_i,
               fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i,
        input  out_ready_i,
        output out_valid_o, out_ctrl_o, out_op1_o, out_op2_o, out_rd_o, out_rd_we_o
    );

    modport master (
        output flush_i,
        output in_valid_i, in_ctrl_i, in_rs1_idx_i, in_rs2_idx_i,
               in_rs1_val_i, in_rs2_val_i, in_imm_i, in_pc_i, in_rd_i, in_rd_we_i,
        input  in_ready_o,
        output fwd_mem_valid_i, fwd_mem_rd_i, fwd_mem_data_i,
               fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i,
        output out_ready_i,
        input  out_valid_o, out_ctrl_o, out_op1_o, out_op2_o, out_rd_o, out_rd_we_o
    );

endinterface

// File: rtl/ex_issue_stage_fwd_snoop.sv
// Replaces one register operand with a forwarded result when a bus targets it.
// MEM is younger than WB so it wins; x0 is hardwired and never forwarded.
module fwd_snoop
    import pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [XLEN-1:0]      val,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic [XLEN-1:0]      fwd_val
);

    always_comb begin
        fwd_val = val;
        if (wb_valid && (wb_rd == idx) && (idx != '0)) begin
            fwd_val = wb_data;
        end
        if (mem_valid && (mem_rd == idx) && (idx != '0)) begin
            fwd_val = mem_data;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// Issue stage in front of the ALU: 2-entry skid buffer (head H, skid S) whose
// held operands track the MEM/WB forwarding buses; outputs come only from H.
module ex_issue_stage
    import alu_pkg::*;
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_issue_stage_if.slave bus
);

    occ_state_e state_q, state_d;
    ex_bundle_t h_q, h_d, s_q, s_d;
    ex_bundle_t in_bundle, h_fwd, s_fwd;

    logic [XLEN-1:0] in_rs1_f, in_rs2_f;
    logic [XLEN-1:0] h_rs1_f, h_rs2_f, s_rs1_f, s_rs2_f;
    logic            accept, pop;

    fwd_snoop u_in_rs1 (
        .idx(bus.in_rs1_idx_i), .val(bus.in_rs1_val_i),
        .mem_valid(bus.fwd_mem_valid_i), .mem_rd(bus.fwd_mem_rd_i), .mem_data(bus.fwd_mem_data_i),
        .wb_valid(bus.fwd_wb_valid_i), .wb_rd(bus.fwd_wb_rd_i), .wb_data(bus.fwd_wb_data_i),
        .fwd_val(in_rs1_f)
    );

    fwd_snoop u_in_rs2 (
        .idx(bus.in_rs2_idx_i), .val(bus.in_rs2_val_i),
        .mem_valid(bus.fwd_mem_valid_i), .mem_rd(bus.fwd_mem_rd_i), .mem_data(bus.fwd_mem_data_i),
        .wb_valid(bus.fwd_wb_valid_i), .wb_rd(bus.fwd_wb_rd_i), .wb_data(bus.fwd_wb_data_i),
        .fwd_val(in_rs2_f)
    );

    fwd_snoop u_h_rs1 (
        .idx(h_q.rs1_idx), .val(h_q.rs1_val),
        .mem_valid(bus.fwd_mem_valid_i), .mem_rd(bus.fwd_mem_rd_i), .mem_data(bus.fwd_mem_data_i),
        .wb_valid(bus.fwd_wb_valid_i), .wb_rd(bus.fwd_wb_rd_i), .wb_data(bus.fwd_wb_data_i),
        .fwd_val(h_rs1_f)
    );

    fwd_snoop u_h_rs2 (
        .idx(h_q.rs2_idx), .val(h_q.rs2_val),
        .mem_valid(bus.fwd_mem_valid_i), .mem_rd(bus.fwd_mem_rd_i), .mem_data(bus.fwd_mem_data_i),
        .wb_valid(bus.fwd_wb_valid_i), .wb_rd(bus.fwd_wb_rd_i), .wb_data(bus.fwd_wb_data_i),
        .fwd_val(h_rs2_f)
    );

    fwd_snoop u_s_rs1 (
        .idx(s_q.rs1_idx), .val(s_q.rs1_val),
        .mem_valid(bus.fwd_mem_valid_i), .mem_rd(bus.fwd_mem_rd_i), .mem_data(bus.fwd_mem_data_i),
        .wb_valid(bus.fwd_wb_valid_i), .wb_rd(bus.fwd_wb_rd_i), .wb_data(bus.fwd_wb_data_i),
        .fwd_val(s_rs1_f)
    );

    fwd_snoop u_s_rs2 (
        .idx(s_q.rs2_idx), .val(s_q.rs2_val),
        .mem_valid(bus.fwd_mem_valid_i), .mem_rd(bus.fwd_mem_rd_i), .mem_data(bus.fwd_mem_data_i),
        .wb_valid(bus.fwd_wb_valid_i), .wb_rd(bus.fwd_wb_rd_i), .wb_data(bus.fwd_wb_data_i),
        .fwd_val(s_rs2_f)
    );

    always_comb begin
        in_bundle         = '0;
        in_bundle.ctrl    = bus.in_ctrl_i;
        in_bundle.rs1_idx = bus.in_rs1_idx_i;
        in_bundle.rs2_idx = bus.in_rs2_idx_i;
        in_bundle.rs1_val = in_rs1_f;
        in_bundle.rs2_val = in_rs2_f;
        in_bundle.imm     = bus.in_imm_i;
        in_bundle.pc      = bus.in_pc_i;
        in_bundle.rd      = bus.in_rd_i;
        in_bundle.rd_we   = bus.in_rd_we_i;

        h_fwd         = h_q;
        h_fwd.rs1_val = h_rs1_f;
        h_fwd.rs2_val = h_rs2_f;
        s_fwd         = s_q;
        s_fwd.rs1_val = s_rs1_f;
        s_fwd.rs2_val = s_rs2_f;
    end

    assign accept = bus.in_valid_i && (state_q != OCC_FULL);
    assign pop    = (state_q != OCC_EMPTY) && bus.out_ready_i;

    // Entries only absorb forwarded values while valid, so an idle head keeps
    // presenting its last operands.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        if (state_q != OCC_EMPTY) h_d = h_fwd;
        if (state_q == OCC_FULL)  s_d = s_fwd;

        if (bus.flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        h_d     = in_bundle;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        h_d = in_bundle;
                    end else if (accept) begin
                        s_d     = in_bundle;
                        state_d = OCC_FULL;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        h_d     = s_fwd;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q <= h_d;
            s_q <= s_d;
        end
    end

    assign bus.in_ready_o  = (state_q != OCC_FULL);
    assign bus.out_valid_o = (state_q != OCC_EMPTY);
    assign bus.out_ctrl_o  = h_q.ctrl;
    assign bus.out_op1_o   = select_operand(h_q.ctrl.op1_sel, h_q.rs1_val, h_q.imm, h_q.pc);
    assign bus.out_op2_o   = select_operand(h_q.ctrl.op2_sel, h_q.rs2_val, h_q.imm, h_q.pc);
    assign bus.out_rd_o    = h_q.rd;
    assign bus.out_rd_we_o = h_q.rd_we;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: expected ALU bundles are queued when
// offered and compared whenever the stage hands one to the ALU.
module tb_ex_issue_stage;
    import alu_pkg::*;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_issue_stage_if bus();

    ex_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    function automatic logic [31:0] model_op(input risk_alu_operand_selector_e sel,
                                             input logic [31:0] r, input logic [31:0] imm,
                                             input logic [31:0] pc);
        case (sel)
            OP_REG:  return r;
            OP_IMM:  return imm;
            OP_PC:   return pc;
            default: return 32'h0;
        endcase
    endfunction

    // r1_final/r2_final are the register values the bundle must carry once all
    // forwarding the test arranges has happened.
    task automatic applyStimulus(input risk_alu_e op,
                                 input risk_alu_operand_selector_e s1,
                                 input risk_alu_operand_selector_e s2,
                                 input logic [4:0] r1i, input logic [31:0] r1v,
                                 input logic [4:0] r2i, input logic [31:0] r2v,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] rd,
                                 input logic [31:0] r1_final, input logic [31:0] r2_final,
                                 input bit push);
        alu_control_t c;
        exp_t e;
        c.operation    = op;
        c.op1_sel      = s1;
        c.op2_sel      = s2;
        c.use_unsigned = 1'b0;
        bus.in_valid_i   = 1'b1;
        bus.in_ctrl_i    = c;
        bus.in_rs1_idx_i = r1i;
        bus.in_rs1_val_i = r1v;
        bus.in_rs2_idx_i = r2i;
        bus.in_rs2_val_i = r2v;
        bus.in_imm_i     = imm;
        bus.in_pc_i      = pc;
        bus.in_rd_i      = rd;
        bus.in_rd_we_i   = (rd != 5'd0);
        if (push) begin
            e.op1   = model_op(s1, r1_final, imm, pc);
            e.op2   = model_op(s2, r2_final, imm, pc);
            e.rd    = rd;
            e.rd_we = (rd != 5'd0);
            e.ctrl  = c;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            checkOutput("pop_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_op1", bus.out_op1_o, e.op1);
                checkOutput("out_op2", bus.out_op2_o, e.op2);
                checkOutput("out_rd", 32'(bus.out_rd_o), 32'(e.rd));
                checkOutput("out_rd_we", 32'(bus.out_rd_we_o), 32'(e.rd_we));
                checkOutput("out_ctrl", 32'(bus.out_ctrl_o), 32'(e.ctrl));
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.flush_i         = 1'b0;
        bus.in_valid_i      = 1'b0;
        bus.in_ctrl_i       = '0;
        bus.in_rs1_idx_i    = '0;
        bus.in_rs2_idx_i    = '0;
        bus.in_rs1_val_i    = '0;
        bus.in_rs2_val_i    = '0;
        bus.in_imm_i        = '0;
        bus.in_pc_i         = '0;
        bus.in_rd_i         = '0;
        bus.in_rd_we_i      = 1'b0;
        bus.fwd_mem_valid_i = 1'b0;
        bus.fwd_mem_rd_i    = '0;
        bus.fwd_mem_data_i  = '0;
        bus.fwd_wb_valid_i  = 1'b0;
        bus.fwd_wb_rd_i     = '0;
        bus.fwd_wb_data_i   = '0;
        bus.out_ready_i     = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready_o), 32'd1);

        // Single ADD with reg/imm operands through an empty stage
        step();
        bus.out_ready_i = 1'b1;
        applyStimulus(ALU_ADD, OP_REG, OP_IMM, 5'd1, 32'h10, 5'd2, 32'h0,
                      32'h5, 32'h100, 5'd4, 32'h10, 32'h0, 1'b1);
        step();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("single_out_valid", 32'(bus.out_valid_o), 32'd1);
        checkOutput("single_in_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        @(negedge clk);
        checkOutput("single_drained", 32'(bus.out_valid_o), 32'd0);

        // Back-to-back A, B, C with the ALU stalled
        step();
        bus.out_ready_i = 1'b0;
        applyStimulus(ALU_SUB, OP_REG, OP_REG, 5'd8, 32'hA1, 5'd9, 32'hA2,
                      32'h0, 32'h200, 5'd5, 32'hA1, 32'hA2, 1'b1);
        step();
        applyStimulus(ALU_AND, OP_IMM, OP_REG, 5'd0, 32'h0, 5'd10, 32'hB2,
                      32'hB0, 32'h204, 5'd6, 32'h0, 32'hB2, 1'b1);
        step();
        applyStimulus(ALU_OR, OP_PC, OP_IMM, 5'd0, 32'h0, 5'd0, 32'h0,
                      32'hC1, 32'hC00, 5'd7, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("full_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("c_held_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        @(negedge clk);
        checkOutput("after_pop_in_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        bus.in_valid_i = 1'b0;
        step();
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        checkOutput("abc_drained", 32'(bus.out_valid_o), 32'd0);
        checkOutput("abc_sb_empty", 32'(sb.size()), 32'd0);

        // Forwarding onto a held head: WB, then MEM beats WB, x0 untouched
        step();
        applyStimulus(ALU_XOR, OP_REG, OP_REG, 5'd3, 32'h1, 5'd0, 32'h0,
                      32'h0, 32'h300, 5'd8, 32'h33, 32'h0, 1'b1);
        step();
        bus.in_valid_i     = 1'b0;
        bus.fwd_wb_valid_i = 1'b1;
        bus.fwd_wb_rd_i    = 5'd3;
        bus.fwd_wb_data_i  = 32'h22;
        @(negedge clk);
        checkOutput("hold_initial_op1", bus.out_op1_o, 32'h1);
        step();
        bus.fwd_wb_data_i   = 32'h44;
        bus.fwd_mem_valid_i = 1'b1;
        bus.fwd_mem_rd_i    = 5'd3;
        bus.fwd_mem_data_i  = 32'h33;
        @(negedge clk);
        checkOutput("hold_wb_op1", bus.out_op1_o, 32'h22);
        step();
        bus.fwd_wb_valid_i = 1'b0;
        bus.fwd_mem_rd_i   = 5'd0;
        bus.fwd_mem_data_i = 32'h99;
        @(negedge clk);
        checkOutput("hold_mem_wins_op1", bus.out_op1_o, 32'h33);
        step();
        bus.fwd_mem_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("hold_x0_op2", bus.out_op2_o, 32'h0);
        checkOutput("hold_x0_op1", bus.out_op1_o, 32'h33);
        step();
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;

        // Forwarding applied on capture of both operands
        step();
        bus.out_ready_i = 1'b1;
        applyStimulus(ALU_ADD, OP_REG, OP_REG, 5'd5, 32'h1, 5'd6, 32'h66,
                      32'h0, 32'h400, 5'd9, 32'h55, 32'h77, 1'b1);
        bus.fwd_mem_valid_i = 1'b1;
        bus.fwd_mem_rd_i    = 5'd5;
        bus.fwd_mem_data_i  = 32'h55;
        bus.fwd_wb_valid_i  = 1'b1;
        bus.fwd_wb_rd_i     = 5'd6;
        bus.fwd_wb_data_i   = 32'h77;
        step();
        bus.in_valid_i      = 1'b0;
        bus.fwd_mem_valid_i = 1'b0;
        bus.fwd_wb_valid_i  = 1'b0;
        step();
        bus.out_ready_i = 1'b0;

        // FULL, pop with MEM forwarding into the skid entry as it moves to H
        step();
        applyStimulus(ALU_ADD, OP_REG, OP_IMM, 5'd2, 32'hF1, 5'd0, 32'h0,
                      32'hF0, 32'h500, 5'd10, 32'hF1, 32'h0, 1'b1);
        step();
        applyStimulus(ALU_SLL, OP_IMM, OP_REG, 5'd0, 32'h0, 5'd7, 32'h7,
                      32'h3, 32'h504, 5'd11, 32'h0, 32'hAB, 1'b1);
        step();
        bus.in_valid_i      = 1'b0;
        bus.out_ready_i     = 1'b1;
        bus.fwd_mem_valid_i = 1'b1;
        bus.fwd_mem_rd_i    = 5'd7;
        bus.fwd_mem_data_i  = 32'hAB;
        @(negedge clk);
        checkOutput("fg_full_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        bus.fwd_mem_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("move_fwd_op2", bus.out_op2_o, 32'hAB);
        checkOutput("move_out_valid", 32'(bus.out_valid_o), 32'd1);
        step();
        bus.out_ready_i = 1'b0;

        // Flush from FULL with a bundle offered in the same cycle
        step();
        applyStimulus(ALU_OR, OP_REG, OP_REG, 5'd12, 32'h12, 5'd13, 32'h13,
                      32'h0, 32'h600, 5'd12, 32'h12, 32'h13, 1'b1);
        step();
        applyStimulus(ALU_AND, OP_REG, OP_REG, 5'd14, 32'h14, 5'd15, 32'h15,
                      32'h0, 32'h604, 5'd13, 32'h14, 32'h15, 1'b1);
        step();
        applyStimulus(ALU_SRA, OP_IMM, OP_IMM, 5'd0, 32'h0, 5'd0, 32'h0,
                      32'hDEAD, 32'h608, 5'd14, 32'h0, 32'h0, 1'b0);
        bus.flush_i = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("preflush_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("flush_in_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        step();
        @(negedge clk);
        checkOutput("flush_no_ghost", 32'(bus.out_valid_o), 32'd0);

        // PC/ZERO operand selection
        applyStimulus(ALU_ADD, OP_PC, OP_ZERO, 5'd1, 32'h11, 5'd2, 32'h22,
                      32'h7, 32'h1000, 5'd15, 32'h11, 32'h22, 1'b1);
        step();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("pc_op1", bus.out_op1_o, 32'h1000);
        checkOutput("zero_op2", bus.out_op2_o, 32'h0);
        step();
        bus.out_ready_i = 1'b0;

        // Reset while FULL
        applyStimulus(ALU_SUB, OP_REG, OP_REG, 5'd1, 32'h1, 5'd2, 32'h2,
                      32'h0, 32'h700, 5'd1, 32'h1, 32'h2, 1'b0);
        step();
        applyStimulus(ALU_SUB, OP_REG, OP_REG, 5'd3, 32'h3, 5'd4, 32'h4,
                      32'h0, 32'h704, 5'd2, 32'h3, 32'h4, 1'b0);
        step();
        bus.in_valid_i = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        checkOutput("prerst_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Accepts decoded instruction bundles from decode over a valid/ready handshake and holds them in a 2-entry skid buffer.
- Keeps held register operands coherent by snooping the MEM and WB forwarding buses.
- Presents fully resolved op1/op2 plus the ALU control bundle to the ALU from registered state, with no combinational path from forwarding inputs to outputs.

Parameters:
- XLEN, 32, datapath width.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  kill all held and incoming bundles.
- in_valid_i  in  1  decode offers a bundle.
- in_ready_o  in/out: out  1  stage can accept.
- in_ctrl_i  in  8  alu_control_t (operation, op1_sel, op2_sel, use_unsigned).
- in_rs1_idx_i / in_rs2_idx_i  in  REG_IDX_W each  source register indices.
- in_rs1_val_i / in_rs2_val_i  in  XLEN each  register-file read values.
- in_imm_i  in  XLEN  sign-extended immediate.
- in_pc_i  in  XLEN  instruction PC.
- in_rd_i  in  REG_IDX_W  destination register.
- in_rd_we_i  in  1  destination write enable.
- fwd_mem_valid_i  in  1  MEM-stage result valid.
- fwd_mem_rd_i  in  REG_IDX_W  MEM-stage destination.
- fwd_mem_data_i  in  XLEN  MEM-stage result.
- fwd_wb_valid_i / fwd_wb_rd_i / fwd_wb_data_i  in  1 / REG_IDX_W / XLEN  WB-stage equivalents.
- out_valid_o  out  1  head bundle valid.
- out_ready_i  in  1  ALU consumes the head.
- out_ctrl_o  out  8  head alu_control_t.
- out_op1_o / out_op2_o  out  XLEN each  resolved operands.
- out_rd_o  out  REG_IDX_W  head destination.
- out_rd_we_o  out  1  head write enable.

Behaviour:
- Reset (rst high at a clk edge):
  - Both entries invalid, so out_valid_o=0.
  - in_ready_o=1 from the first cycle after reset.
  - Entry payloads are don't-care.
  - Inputs are ignored while rst is high.
- Storage: head entry H and skid entry S. Each holds ctrl, rs1/rs2 idx and val, imm, pc, rd, rd_we.
- Occupancy states:
  - EMPTY: no entries valid.
  - ONE: H valid.
  - FULL: H and S valid.
- Handshakes:
  - in_ready_o = !S.valid.
  - Accept = in_valid_i & in_ready_o.
  - Pop = out_valid_o & out_ready_i.
- Transitions:
  - EMPTY + accept -> ONE (new bundle into H).
  - ONE + accept & !pop -> FULL (new bundle into S).
  - ONE + accept & pop -> ONE (new bundle into H).
  - ONE + pop & !accept -> EMPTY.
  - FULL + pop -> ONE (S moves to H). Accept is impossible in FULL.
  - All other cases hold state.
- Latency: a bundle accepted at edge N is visible on out_* in cycle N+1 when the stage was EMPTY, or ONE with a pop at N.
- Ordering: strictly in order.
- Forwarding on capture: an incoming rs value is replaced when a forwarding bus matches its index.
- Forwarding on hold: every cycle, each valid entry (H and S) replaces its stored rs1/rs2 value when a bus matches.
  - The updated value is used after the edge.
  - When S moves to H, the same-edge forwarding update applies to the moved value.
- Forwarding match rule: valid & rd==idx & idx!=0.
  - MEM has priority over WB.
  - x0 is never forwarded.
- Operand mux, combinational from H only. Applies to both op1_sel and op2_sel:
  - OP_REG selects the stored rs value (rs1 for op1, rs2 for op2).
  - OP_IMM selects imm.
  - OP_PC selects pc.
  - OP_ZERO selects 0.
- out_ctrl_o, out_rd_o and out_rd_we_o come straight from H.
- When out_valid_o=0, out_* hold their last values. The consumer must ignore them.
- Flush:
  - flush_i high at an edge invalidates H and S.
  - Any bundle offered in that cycle is dropped even if in_ready_o=1.
  - A pop in the same cycle is still seen by the ALU; the stage does not suppress the downstream handshake.
  - Next cycle: EMPTY, in_ready_o=1.
- rst has priority over flush_i, which has priority over accept/pop.

Decomposition:
- New package pipe_pkg:
  - ex_bundle_t packed struct (ctrl as alu_pkg::alu_control_t, rs idx/val, imm, pc, rd, rd_we).
  - XLEN and REG_IDX_W constants.
- alu_control_t, risk_alu_e and risk_alu_operand_selector_e stay in alu_pkg and are imported.
- One sub-module, fwd_snoop: given idx, current value and both buses, returns the forwarded value. It is instantiated four times (H/S × rs1/rs2) plus twice on the input path.

Test Plan:
- Reset, then offer ADD bundle with op1_sel=OP_REG, rs1 val 0x10, op2_sel=OP_IMM, imm 0x5, out_ready_i=1 -> next cycle out_valid_o=1, op1=0x10, op2=0x5; in_ready_o stays 1.
- Hold out_ready_i=0 and offer 3 bundles back-to-back -> first two accepted, in_ready_o=0 after the second, third held by decode; raise out_ready_i -> outputs emerge in order A,B, then C accepted.
- Bundle held in H with rs1_idx=3 (val 0x1); pulse fwd_wb (rd=3, 0x22), then fwd_mem (rd=3, 0x33) while both are also driven the same cycle with WB=0x44 -> op1 ends 0x33 (MEM wins); fwd with rd=0 leaves rs of idx 0 as 0.
- FULL state with S rs2_idx=7, pop and fwd_mem (rd=7, 0xAB) in the same cycle -> the next head shows op2=0xAB.
- FULL state, assert flush_i together with in_valid_i -> next cycle out_valid_o=0, in_ready_o=1, the offered bundle never appears.
- op1_sel=OP_PC with pc 0x1000, op2_sel=OP_ZERO -> op1=0x1000, op2=0; assert rst mid-FULL -> out_valid_o=0 next cycle.
